// File: rtl/am_clock_comp_tx.sv
// -----------------------------------------------------------------------------
// am_clock_comp_tx
//   TX clock compensator between the 64b/66b encoder and the scrambler.
//   Every AM_BLOCK_PERIOD*N_LANES accepted blocks it opens N_LANES tagged
//   alignment-marker slots. Each slot is repaid by deleting one idle block
//   from the MII side. Deletion credit is tracked by a saturating counter, and
//   the blocks are buffered in a first-word-fall-through FIFO. Rate-matching
//   faults are reported as one-cycle overflow/underflow pulses.
//
// Ports
//   i_clock        clock
//   i_reset_n      asynchronous active-low reset
//   i_enable       global clock enable; low freezes all state
//   i_valid        i_data qualifier
//   i_data         encoded block from the MII side
//   o_data         block to the scrambler (registered)
//   o_valid        o_data qualifier (registered)
//   o_aligner_tag  marks an AM slot (registered)
//   o_overflow     one-cycle pulse: block dropped because the FIFO was full
//   o_underflow    one-cycle pulse: FIFO empty, filler idle emitted
//   o_del_count / o_ovf_count / o_unf_count
//                  saturating event counters, present only when the
//                  CLOCK_COMP_STATS_EN macro is defined
// -----------------------------------------------------------------------------
module am_clock_comp_tx #(
  parameter int NB_DATA         = 66,
  parameter int AM_BLOCK_PERIOD = 16384,
  parameter int N_LANES         = 20,
  parameter int FIFO_DEPTH      = 32,
  parameter int CREDIT_MAX      = 2 * N_LANES
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_aligner_tag,
  output logic               o_overflow,
  output logic               o_underflow
`ifdef CLOCK_COMP_STATS_EN
  ,
  output logic [31:0]        o_del_count,
  output logic [31:0]        o_ovf_count,
  output logic [31:0]        o_unf_count
`endif
);

  localparam int NB_ADDR       = $clog2(FIFO_DEPTH);
  localparam int PERIOD_BLOCKS = AM_BLOCK_PERIOD * N_LANES;
  localparam int PW            = $clog2(PERIOD_BLOCKS);
  localparam int CW            = $clog2(CREDIT_MAX + 1);

  localparam logic [NB_DATA-1:0] PCS_IDLE    = NB_DATA'(66'h1_E000_0000_0000_0000);
  localparam logic [PW-1:0]      PERIOD_LAST = PW'(PERIOD_BLOCKS - 1);
  localparam logic [PW-1:0]      SLOT_COUNT  = PW'(N_LANES);
  localparam logic [CW-1:0]      CREDIT_TOP  = CW'(CREDIT_MAX);

  // State registers
  logic [PW-1:0]      period_q, period_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [NB_ADDR:0]   wptr_q, wptr_d;
  logic [NB_ADDR:0]   rptr_q, rptr_d;
  logic [NB_DATA-1:0] mem_q [FIFO_DEPTH];
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               tag_q, tag_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Per-step decisions
  logic step_s, am_slot_s, is_idle_s, empty_s, full_s;
  logic del_s, rd_s, wr_req_s, wr_s, ovf_s, unf_s;

  assign step_s    = i_enable & i_valid;
  assign am_slot_s = (period_q < SLOT_COUNT);
  assign is_idle_s = (i_data == PCS_IDLE);
  assign empty_s   = (wptr_q == rptr_q);
  // Full: same slot index, opposite wrap bit.
  assign full_s    = (wptr_q[NB_ADDR] != rptr_q[NB_ADDR]) &&
                     (wptr_q[NB_ADDR-1:0] == rptr_q[NB_ADDR-1:0]);
  assign del_s     = step_s & is_idle_s & (credit_q != '0);
  assign rd_s      = step_s & ~am_slot_s & ~empty_s;
  assign wr_req_s  = step_s & ~del_s;
  // A read in the same step frees a slot, so a full FIFO still accepts the write.
  assign wr_s      = wr_req_s & (~full_s | rd_s);
  assign ovf_s     = wr_req_s & full_s & ~rd_s;
  assign unf_s     = step_s & ~am_slot_s & empty_s;

  // Next-state logic for counters, pointers and the output stage.
  always_comb begin
    period_d = period_q;
    credit_d = credit_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    tag_d    = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;

    if (step_s) begin
      period_d = (period_q == PERIOD_LAST) ? '0 : period_q + PW'(1);

      // Slot earned and idle repaid in the same step cancel out.
      if (am_slot_s && !del_s) begin
        credit_d = (credit_q == CREDIT_TOP) ? credit_q : credit_q + CW'(1);
      end else if (del_s && !am_slot_s) begin
        credit_d = credit_q - CW'(1);
      end

      if (wr_s) wptr_d = wptr_q + (NB_ADDR+1)'(1);
      if (rd_s) rptr_d = rptr_q + (NB_ADDR+1)'(1);

      data_d  = rd_s ? mem_q[rptr_q[NB_ADDR-1:0]] : PCS_IDLE;
      valid_d = 1'b1;
      tag_d   = am_slot_s;
      ovf_d   = ovf_s;
      unf_d   = unf_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge i_clock) begin
    if (wr_s) mem_q[wptr_q[NB_ADDR-1:0]] <= i_data;
  end

  // Counters, pointers and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      period_q <= '0;
      credit_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      data_q   <= PCS_IDLE;
      valid_q  <= 1'b0;
      tag_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      credit_q <= credit_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_aligner_tag = tag_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

`ifdef CLOCK_COMP_STATS_EN
  logic [31:0] del_cnt_q, ovf_cnt_q, unf_cnt_q;

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      del_cnt_q <= 32'd0;
      ovf_cnt_q <= 32'd0;
      unf_cnt_q <= 32'd0;
    end else begin
      if (del_s && (del_cnt_q != 32'hFFFF_FFFF)) del_cnt_q <= del_cnt_q + 32'd1;
      if (ovf_s && (ovf_cnt_q != 32'hFFFF_FFFF)) ovf_cnt_q <= ovf_cnt_q + 32'd1;
      if (unf_s && (unf_cnt_q != 32'hFFFF_FFFF)) unf_cnt_q <= unf_cnt_q + 32'd1;
    end
  end

  assign o_del_count = del_cnt_q;
  assign o_ovf_count = ovf_cnt_q;
  assign o_unf_count = unf_cnt_q;
`endif

endmodule

// File: tb/tb_am_clock_comp_tx.sv
// Bench for am_clock_comp_tx with AM_BLOCK_PERIOD=8, N_LANES=2, FIFO_DEPTH=8.
// A behavioural queue model predicts every output step; predictions go to a
// scoreboard and are compared when the DUT raises o_valid. Directed checks
// cover the specific scenarios on top of the scoreboard.
module tb_am_clock_comp_tx;
  localparam int NB    = 66;
  localparam int AMP   = 8;
  localparam int NL    = 2;
  localparam int DEPTH = 8;
  localparam int CMAX  = 2 * NL;
  localparam int PER   = AMP * NL;
  localparam logic [65:0] IDLE = 66'h1_E000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          vld = 1'b0;
  logic [NB-1:0] din = '0;
  logic [NB-1:0] o_data;
  logic          o_valid, o_aligner_tag, o_overflow, o_underflow;
`ifdef CLOCK_COMP_STATS_EN
  logic [31:0]   o_del_count, o_ovf_count, o_unf_count;
`endif

  am_clock_comp_tx #(
    .NB_DATA(NB), .AM_BLOCK_PERIOD(AMP), .N_LANES(NL),
    .FIFO_DEPTH(DEPTH), .CREDIT_MAX(CMAX)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vld),
    .i_data(din), .o_data(o_data), .o_valid(o_valid),
    .o_aligner_tag(o_aligner_tag), .o_overflow(o_overflow),
    .o_underflow(o_underflow)
`ifdef CLOCK_COMP_STATS_EN
    , .o_del_count(o_del_count), .o_ovf_count(o_ovf_count),
    .o_unf_count(o_unf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [65:0] data;
    logic        tag;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [65:0] mq[$];
  int          per = 0;
  int          cred = 0;
  logic [65:0] obs_data[$];
  logic        obs_tag[$];
  logic        obs_ovf[$];
  logic        obs_unf[$];
  int          n_vec = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] dat(input int base, input int k);
    return {2'b10, 16'hDA7A, 16'(base), 32'(k)};
  endfunction

  // Reference model of one accepted step.
  task automatic model_step(input logic [65:0] d);
    exp_t e;
    bit   slot, del;
    slot   = (per < NL);
    del    = (d == IDLE) && (cred > 0);
    e.tag  = slot;
    e.ovf  = 1'b0;
    e.unf  = 1'b0;
    e.data = IDLE;
    if (!slot) begin
      if (mq.size() > 0) e.data = mq.pop_front();
      else e.unf = 1'b1;
    end
    if (!del) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else e.ovf = 1'b1;
    end
    if (slot && !del) cred = (cred < CMAX) ? cred + 1 : CMAX;
    else if (del && !slot) cred = cred - 1;
    per = (per == PER - 1) ? 0 : per + 1;
    sb.push_back(e);
  endtask

  task automatic step(input logic [65:0] d);
    @(posedge clk); #1;
    en = 1'b1; vld = 1'b1; din = d;
    model_step(d);
  endtask

  // Stop stepping and let the last output reach the monitor.
  task automatic drain();
    @(posedge clk); #1;
    en = 1'b0; vld = 1'b0;
    @(posedge clk); #3;
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_tag.delete(); obs_ovf.delete(); obs_unf.delete();
  endtask

  task automatic check_reset_state();
    chk("rst_data", o_data, IDLE);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_tag", o_aligner_tag, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_unf", o_underflow, 1'b0);
  endtask

  task automatic do_reset();
    drain();
    chk("sb_drained", 66'(sb.size()), 66'(0));
    rst_n = 1'b0;
    #2;
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete(); per = 0; cred = 0; sb.delete();
    clear_obs();
  endtask

  // Monitor: pop one prediction per valid output, otherwise expect quiet flags.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (o_valid === 1'b1) begin
        obs_data.push_back(o_data);
        obs_tag.push_back(o_aligner_tag);
        obs_ovf.push_back(o_overflow);
        obs_unf.push_back(o_underflow);
        n_vec++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_spurious: observed output %h expected no output", o_data);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", o_data, e.data);
          chk("sb_tag", o_aligner_tag, e.tag);
          chk("sb_ovf", o_overflow, e.ovf);
          chk("sb_unf", o_underflow, e.unf);
        end
      end else begin
        chk("quiet_tag", o_aligner_tag, 1'b0);
        chk("quiet_ovf", o_overflow, 1'b0);
        chk("quiet_unf", o_underflow, 1'b0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int first_ovf, late_unf, ovf_cnt, stale;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Continuous non-idle data: slots, first data, periodic tags, overflow.
    clear_obs();
    for (int k = 0; k < 70; k++) step(dat(1, k));
    drain();
    chk("p1_count", 66'(obs_data.size()), 66'(70));
    chk("p1_tag0", obs_tag[0], 1'b1);
    chk("p1_tag1", obs_tag[1], 1'b1);
    chk("p1_slot_data", obs_data[0], IDLE);
    chk("p1_tag2", obs_tag[2], 1'b0);
    chk("p1_first_data", obs_data[2], dat(1, 0));
    chk("p1_tag16", obs_tag[16], 1'b1);
    chk("p1_tag17", obs_tag[17], 1'b1);
    chk("p1_tag18", obs_tag[18], 1'b0);
    first_ovf = -1;
    for (int i = 0; i < obs_ovf.size(); i++)
      if (obs_ovf[i] && first_ovf < 0) first_ovf = i;
    chk("p1_first_ovf", 66'(first_ovf), 66'(64));

    // Alternating data/idle, with an enable-low window mid-stream.
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      if (k == 500) begin
        @(posedge clk); #1;
        en = 1'b0; vld = 1'b1; din = dat(2, 9999);
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk("en_low_valid", o_valid, 1'b0);
        end
      end
      step((k % 2 == 1) ? IDLE : dat(2, k));
    end
    drain();
    chk("p2_count", 66'(obs_data.size()), 66'(1000));
    ovf_cnt = 0;
    late_unf = 0;
    for (int i = 0; i < obs_ovf.size(); i++) begin
      if (obs_ovf[i]) ovf_cnt++;
      if (obs_unf[i] && i >= PER) late_unf++;
    end
    chk("p2_no_ovf", 66'(ovf_cnt), 66'(0));
    chk("p2_no_late_unf", 66'(late_unf), 66'(0));

    // Idle at credit 0 is queued; idle at a slot with credit 1 is deleted.
    do_reset();
    step(IDLE); step(IDLE); step(dat(3, 0)); step(dat(3, 1));
    step(IDLE); step(IDLE); step(dat(3, 2)); step(dat(3, 3));
    drain();
    chk("p3_queued_idle", obs_data[2], IDLE);
    chk("p3_queued_idle_unf", obs_unf[2], 1'b0);
    chk("p3_order_a", obs_data[3], dat(3, 0));
    chk("p3_order_b", obs_data[4], dat(3, 1));
    chk("p3_unf5", obs_unf[5], 1'b1);
    chk("p3_idle6_unf", obs_unf[6], 1'b0);
    chk("p3_order_c", obs_data[7], dat(3, 2));

    // Reset mid-period with five entries queued.
    do_reset();
    for (int k = 0; k < 33; k++) step(dat(4, k));
    do_reset();
    for (int k = 0; k < 10; k++) step(dat(5, k));
    drain();
    chk("p4_tag0", obs_tag[0], 1'b1);
    chk("p4_tag1", obs_tag[1], 1'b1);
    chk("p4_first", obs_data[2], dat(5, 0));
    chk("p4_second", obs_data[3], dat(5, 1));
    stale = 0;
    for (int i = 0; i < obs_data.size(); i++)
      if (obs_data[i][47:32] == 16'd4 && obs_data[i][65:48] == {2'b10, 16'hDA7A}) stale++;
    chk("p4_no_stale", 66'(stale), 66'(0));
    chk("p4_sb_empty", 66'(sb.size()), 66'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
